conv_arbiter: RTL and testbench

Request scheduler for the code-converter datapath (the `main` converter). It shares the single converter between two requesters using round-robin arbitration. For each granted request it drives the datapath input and exactly one conversion enable (`gcon`, `bcon1`, `bcon2`, `xscon`), captures the selected converter output, and returns it to the requester with a one-cycle acknowledge. It sits between requester logic and the converter, and replaces the free-running `start`/`stop` sequencing when more than one client needs conversions.

---
 rtl/conv_arbiter_if.sv | 44 ++++
 rtl/conv_arbiter.sv | 176 +++++++++++++++++
 tb/tb_conv_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/conv_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared code converter.
// Latency: none, wires only.
// Backpressure: requesters hold req until their ack. The converter is combinational and never stalls.
interface conv_arbiter_if;
    // requester side
    logic       req0;
    logic       req1;
    logic [1:0] op0;
    logic [1:0] op1;
    logic [3:0] din0;
    logic [3:0] din1;
    logic       ack0;
    logic       ack1;
    logic [3:0] result;
    logic       err;
    logic       busy;

    // converter side
    logic [3:0] dp_din;
    logic       gcon;
    logic       bcon1;
    logic       bcon2;
    logic       xscon;
    logic [3:0] gout;
    logic [3:0] bout1;
    logic [3:0] bout2;
    logic [3:0] xsout;

    // environment view: requesters plus the converter model
    modport master (
        output req0, req1, op0, op1, din0, din1,
        input  ack0, ack1, result, err, busy,
        input  dp_din, gcon, bcon1, bcon2, xscon,
        output gout, bout1, bout2, xsout
    );

    // arbiter view
    modport slave (
        input  req0, req1, op0, op1, din0, din1,
        output ack0, ack1, result, err, busy,
        output dp_din, gcon, bcon1, bcon2, xscon,
        input  gout, bout1, bout2, xsout
    );
endinterface

// File: rtl/conv_arbiter.sv
// Round-robin scheduler sharing one code converter between two requesters; optional range check: CONV_RANGE_CHECK_EN.
// Latency: 3 cycles from the IDLE sampling edge to a one-cycle ack. A range error acks after 1 cycle.
// Backpressure: requesters hold req until ack. The loser waits for the next IDLE, giving 1 job every 4 cycles.
module conv_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    conv_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [1:0] OP_B2G  = 2'b00;
    localparam logic [1:0] OP_G2B  = 2'b01;
    localparam logic [1:0] OP_B2XS = 2'b10;
    localparam logic [1:0] OP_XS2B = 2'b11;

    state_t     state;
    state_t     state_nxt;

    // arbitration bookkeeping and the job in flight
    logic       last;
    logic       sel;
    logic [1:0] op_q;
    logic [3:0] din_q;
    logic [3:0] result_q;
`ifdef CONV_RANGE_CHECK_EN
    logic       err_q;
`endif

    // grant-side combinational signals, meaningful only in IDLE
    logic       gnt_vld;
    logic       gnt_id;
    logic [1:0] gnt_op;
    logic [3:0] gnt_din;
    logic       range_err;
    logic [3:0] conv_mux;

    // Round-robin pick: a lone request wins, and a tie goes to the requester not served last.
    always_comb begin
        gnt_vld = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            gnt_id = ~last;
        end else begin
            gnt_id = bus.req1;
        end
        gnt_op  = gnt_id ? bus.op1  : bus.op0;
        gnt_din = gnt_id ? bus.din1 : bus.din0;
    end

    // Operand range screen for the xs3 conversions. It is constant 0 when the check is compiled out.
    always_comb begin
        range_err = 1'b0;
`ifdef CONV_RANGE_CHECK_EN
        if (gnt_op == OP_B2XS && gnt_din > 4'd9) begin
            range_err = 1'b1;
        end
        if (gnt_op == OP_XS2B && (gnt_din < 4'd3 || gnt_din > 4'd12)) begin
            range_err = 1'b1;
        end
`endif
    end

    // Select the converter output that matches the latched operation.
    always_comb begin
        conv_mux = 4'd0;
        case (op_q)
            OP_B2G:  conv_mux = bus.gout;
            OP_G2B:  conv_mux = bus.bout1;
            OP_B2XS: conv_mux = bus.xsout;
            OP_XS2B: conv_mux = bus.bout2;
            default: conv_mux = 4'd0;
        endcase
    end

    // State register. A synchronous reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: DRIVE, SAMPLE and ACK step unconditionally. An errored grant skips straight to ACK.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    state_nxt = range_err ? ACK : DRIVE;
                end
            end
            DRIVE:   state_nxt = SAMPLE;
            SAMPLE:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the job on grant and capture the converter result on the SAMPLE to ACK edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last     <= 1'b1;
            sel      <= 1'b0;
            op_q     <= 2'b00;
            din_q    <= 4'd0;
            result_q <= 4'd0;
`ifdef CONV_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        last     <= gnt_id;
                        sel      <= gnt_id;
                        op_q     <= gnt_op;
                        din_q    <= gnt_din;
                        result_q <= 4'd0;
`ifdef CONV_RANGE_CHECK_EN
                        err_q    <= range_err;
`endif
                    end
                end
                SAMPLE: begin
                    result_q <= conv_mux;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: the operand and one enable during DRIVE and SAMPLE, and the ack with its result during ACK.
    always_comb begin
        bus.busy   = (state != IDLE);
        bus.dp_din = 4'd0;
        bus.gcon   = 1'b0;
        bus.bcon1  = 1'b0;
        bus.bcon2  = 1'b0;
        bus.xscon  = 1'b0;
        bus.ack0   = 1'b0;
        bus.ack1   = 1'b0;
        bus.result = 4'd0;
        bus.err    = 1'b0;
        case (state)
            DRIVE, SAMPLE: begin
                bus.dp_din = din_q;
                case (op_q)
                    OP_B2G:  bus.gcon  = 1'b1;
                    OP_G2B:  bus.bcon1 = 1'b1;
                    OP_B2XS: bus.xscon = 1'b1;
                    OP_XS2B: bus.bcon2 = 1'b1;
                    default: begin
                    end
                endcase
            end
            ACK: begin
                bus.ack0   = ~sel;
                bus.ack1   = sel;
                bus.result = result_q;
`ifdef CONV_RANGE_CHECK_EN
                bus.err    = err_q;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter with a behavioural model of the code converter.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: requests are held until ack and then dropped within the ack cycle.
module tb_conv_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    conv_arbiter_if bus ();

    conv_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Converter model: each output is live only while its own enable is high.
    always_comb begin
        bus.gout  = bus.gcon  ? (bus.dp_din ^ (bus.dp_din >> 1)) : 4'd0;
        bus.bout1 = bus.bcon1 ? gray2bin(bus.dp_din)             : 4'd0;
        bus.xsout = bus.xscon ? (bus.dp_din + 4'd3)              : 4'd0;
        bus.bout2 = bus.bcon2 ? (bus.dp_din - 4'd3)              : 4'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pack {gcon,bcon1,bcon2,xscon} into one word.
    function automatic logic [7:0] ens();
        return {4'd0, bus.gcon, bus.bcon1, bus.bcon2, bus.xscon};
    endfunction

    localparam logic [7:0] EN_G  = 8'b1000;
    localparam logic [7:0] EN_B1 = 8'b0100;
    localparam logic [7:0] EN_B2 = 8'b0010;
    localparam logic [7:0] EN_XS = 8'b0001;

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0  = 2'd0; bus.op1  = 2'd0;
        bus.din0 = 4'd0; bus.din1 = 4'd0;

        // reset state
        tick(); tick();
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_en", ens(), 8'd0);
        check("rst_ack", {6'd0, bus.ack1, bus.ack0}, 8'd0);
        check("rst_dpdin", {4'd0, bus.dp_din}, 8'd0);
        check("rst_res", {3'd0, bus.err, bus.result}, 8'd0);
        rst_n = 1'b1;
        tick();

        // single req0: bin->gray of 0010
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.din0 = 4'b0010;
        tick();
        check("t1_drive_en", ens(), EN_G);
        check("t1_drive_dp", {4'd0, bus.dp_din}, 8'h02);
        check("t1_drive_busy", {7'd0, bus.busy}, 8'd1);
        tick();
        check("t1_sample_en", ens(), EN_G);
        check("t1_sample_dp", {4'd0, bus.dp_din}, 8'h02);
        tick();
        check("t1_ack", {6'd0, bus.ack1, bus.ack0}, 8'b01);
        check("t1_result", {3'd0, bus.err, bus.result}, 8'h03);
        check("t1_ack_en", ens(), 8'd0);
        bus.req0 = 1'b0;
        tick();
        check("t1_idle", {5'd0, bus.busy, bus.ack1, bus.ack0}, 8'd0);

        // fresh reset so last=1 and req0 wins the tie
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.op0 = 2'b01; bus.din0 = 4'b0111;
        bus.req1 = 1'b1; bus.op1 = 2'b10; bus.din1 = 4'b0101;
        tick();
        check("t2_drive_en", ens(), EN_B1);
        check("t2_drive_dp", {4'd0, bus.dp_din}, 8'h07);
        bus.din0 = 4'hF; bus.op0 = 2'b00;   // must not disturb the latched job
        tick();
        check("t2_latch_dp", {4'd0, bus.dp_din}, 8'h07);
        check("t2_latch_en", ens(), EN_B1);
        tick();
        check("t2_ack0", {6'd0, bus.ack1, bus.ack0}, 8'b01);
        check("t2_res0", {3'd0, bus.err, bus.result}, 8'h05);
        bus.req0 = 1'b0;
        tick();
        check("t2_gap", {5'd0, bus.busy, bus.ack1, bus.ack0}, 8'd0);
        tick();
        check("t2_drive1_en", ens(), EN_XS);
        check("t2_drive1_dp", {4'd0, bus.dp_din}, 8'h05);
        tick();
        check("t2_sample1_en", ens(), EN_XS);
        tick();
        check("t2_ack1", {6'd0, bus.ack1, bus.ack0}, 8'b10);
        check("t2_res1", {3'd0, bus.err, bus.result}, 8'h08);
        bus.req1 = 1'b0;
        tick();
        check("t2_idle", {7'd0, bus.busy}, 8'd0);

        // both held for 4 jobs; last is 1, so grants go 0,1,0,1
        bus.req0 = 1'b1; bus.op0 = 2'b11; bus.din0 = 4'd4;   // xs3->bin: 1
        bus.req1 = 1'b1; bus.op1 = 2'b10; bus.din1 = 4'd6;   // bin->xs3: 9
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t3_drive_en", ens(), (j % 2 == 0) ? EN_B2 : EN_XS);
            tick();
            check("t3_sample_en", ens(), (j % 2 == 0) ? EN_B2 : EN_XS);
            tick();
            check("t3_ack", {6'd0, bus.ack1, bus.ack0}, (j % 2 == 0) ? 8'b01 : 8'b10);
            check("t3_res", {3'd0, bus.err, bus.result}, (j % 2 == 0) ? 8'h01 : 8'h09);
            check("t3_ack_busy", {7'd0, bus.busy}, 8'd1);
            tick();
            check("t3_gap_busy", {7'd0, bus.busy}, 8'd0);
            if (j == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
        end
        tick();
        check("t3_quiet", {7'd0, bus.busy}, 8'd0);

        // reset during SAMPLE of a req1 job (xs3->bin of 1100)
        bus.req1 = 1'b1; bus.op1 = 2'b11; bus.din1 = 4'b1100;
        tick();
        check("t4_drive_en", ens(), EN_B2);
        tick();
        check("t4_sample_en", ens(), EN_B2);
        rst_n = 1'b0;
        tick();
        check("t4_rst_en", ens(), 8'd0);
        check("t4_rst_ack", {5'd0, bus.busy, bus.ack1, bus.ack0}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("t4_re_drive_en", ens(), EN_B2);
        check("t4_re_drive_dp", {4'd0, bus.dp_din}, 8'h0C);
        tick();
        check("t4_re_sample_en", ens(), EN_B2);
        tick();
        check("t4_ack1", {6'd0, bus.ack1, bus.ack0}, 8'b10);
        check("t4_res", {3'd0, bus.err, bus.result}, 8'h09);
        bus.req1 = 1'b0;
        tick();
        check("t4_idle", {7'd0, bus.busy}, 8'd0);

        // xs3->bin of 0001: out of range when the check is compiled in
        bus.req0 = 1'b1; bus.op0 = 2'b11; bus.din0 = 4'b0001;
`ifdef CONV_RANGE_CHECK_EN
        tick();
        check("t5_err_ack", {6'd0, bus.ack1, bus.ack0}, 8'b01);
        check("t5_err_res", {3'd0, bus.err, bus.result}, 8'h10);
        check("t5_err_en", ens(), 8'd0);
        bus.req0 = 1'b0;
        tick();
        check("t5_err_idle", {7'd0, bus.busy}, 8'd0);
`else
        tick();
        check("t5_drive_en", ens(), EN_B2);
        tick();
        check("t5_sample_en", ens(), EN_B2);
        tick();
        check("t5_ack", {6'd0, bus.ack1, bus.ack0}, 8'b01);
        check("t5_res", {3'd0, bus.err, bus.result}, 8'h0E);
        bus.req0 = 1'b0;
        tick();
        check("t5_idle", {7'd0, bus.busy}, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
